voice_sequencer: RTL

VOICE_SEQUENCER -- requirements
Module: voice_sequencer

---
 rtl/voice_sequencer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/voice_sequencer.sv
// voice_sequencer: four-voice wavetable sequencer. Each falling edge of the
// sample clock starts one frame that walks the voices in turn. For each voice
// it reads one wavetable word through the shared ROM port and adds it to an
// accumulator. At the end of the frame the accumulator becomes the new output
// sample.
// Optional feature macro: VOICE_SEQ_SAT_EN. When it is defined, the output
// saturates to the 16-bit signed range. When it is undefined, the output takes
// the low 16 bits of the accumulator and wraps.
module voice_sequencer #(
    parameter int unsigned RAMP_MAX = 60000
) (
    input  logic        iCLK_18_4,
    input  logic        iRST_N,
    input  logic        iLRCK,
    input  logic [3:0]  iKey_on,
    input  logic [15:0] iInc0,
    input  logic [15:0] iInc1,
    input  logic [15:0] iInc2,
    input  logic [15:0] iInc3,
    output logic [5:0]  oRom_addr,
    output logic        oRom_rd,
    input  logic [15:0] iRom_data,
    output logic [15:0] oSample,
    output logic        oSample_vld,
    output logic        oBusy,
    output logic        oOverrun
);

    localparam int unsigned NUM_VOICES = 4;
    localparam int unsigned PHASE_W    = 16;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ACC_W      = 18;
    localparam int unsigned VIDX_W     = 2;

    localparam logic [PHASE_W-1:0] RAMP_LIM = PHASE_W'(RAMP_MAX);
    localparam logic [VIDX_W-1:0]  LAST_V   = VIDX_W'(NUM_VOICES - 1);

`ifdef VOICE_SEQ_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACC,
        S_DONE
    } state_t;

    // Synchroniser and edge-detect flops
    logic lrck_s1_q, lrck_s2_q, lrck_d_q;
    logic lrck_s1_d, lrck_s2_d, lrck_d_d;

    // Frame control and datapath state
    state_t                    state_q, state_d;
    logic [VIDX_W-1:0]         v_q, v_d;
    logic [NUM_VOICES-1:0]     key_q, key_d;
    logic [PHASE_W-1:0]        inc_q   [NUM_VOICES];
    logic [PHASE_W-1:0]        inc_d   [NUM_VOICES];
    logic [PHASE_W-1:0]        phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]        phase_d [NUM_VOICES];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  rom_data_q, rom_data_d;

    // Registered outputs
    logic [ADDR_W-1:0]         rom_addr_q, rom_addr_d;
    logic                      rom_rd_q, rom_rd_d;
    logic [DATA_W-1:0]         sample_q, sample_d;
    logic                      sample_vld_q, sample_vld_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;

    // Combinational helpers
    logic                      start_c;
    logic [VIDX_W-1:0]         v_nxt_c;
    logic signed [ACC_W-1:0]   rom_ext_c;
    logic signed [ACC_W-1:0]   acc_sum_c;
    logic [DATA_W-1:0]         sample_fmt_c;

    assign oRom_addr   = rom_addr_q;
    assign oRom_rd     = rom_rd_q;
    assign oSample     = sample_q;
    assign oSample_vld = sample_vld_q;
    assign oBusy       = busy_q;
    assign oOverrun    = overrun_q;

    // Frame start: falling edge of the synchronised sample clock
    assign start_c = lrck_d_q & ~lrck_s2_q;

    // Voice contribution and running sum; a keyed-off voice adds zero
    always_comb begin
        v_nxt_c   = v_q + VIDX_W'(1);
        rom_ext_c = '0;
        if (key_q[v_q]) begin
            rom_ext_c = ACC_W'(rom_data_q);
        end
        acc_sum_c = acc_q + rom_ext_c;
    end

    // Final accumulator-to-sample conversion (saturating or wrapping)
    always_comb begin
        sample_fmt_c = acc_sum_c[DATA_W-1:0];
`ifdef VOICE_SEQ_SAT_EN
        if (acc_sum_c > SAT_HI) begin
            sample_fmt_c = 16'h7FFF;
        end else if (acc_sum_c < SAT_LO) begin
            sample_fmt_c = 16'h8000;
        end
`endif
    end

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        lrck_s1_d    = iLRCK;
        lrck_s2_d    = lrck_s1_q;
        lrck_d_d     = lrck_s2_q;
        state_d      = state_q;
        v_d          = v_q;
        key_d        = key_q;
        inc_d        = inc_q;
        phase_d      = phase_q;
        acc_d        = acc_q;
        rom_data_d   = rom_data_q;
        rom_addr_d   = rom_addr_q;
        rom_rd_d     = 1'b0;
        sample_d     = sample_q;
        sample_vld_d = 1'b0;
        busy_d       = busy_q;
        overrun_d    = overrun_q;

        // A start that arrives while a frame is still running is dropped
        if (start_c && busy_q) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    key_d    = iKey_on;
                    inc_d[0] = iInc0;
                    inc_d[1] = iInc1;
                    inc_d[2] = iInc2;
                    inc_d[3] = iInc3;
                    acc_d    = '0;
                    v_d      = '0;
                    busy_d   = 1'b1;
                    state_d  = S_ISSUE;
                    // Voice 0 read is set up here so it is visible during ISSUE
                    rom_rd_d = iKey_on[0];
                    if (iKey_on[0]) begin
                        rom_addr_d = phase_q[0][PHASE_W-1 -: ADDR_W];
                    end
                end
            end
            S_ISSUE: begin
                if (key_q[v_q]) begin
                    if (phase_q[v_q] > RAMP_LIM) begin
                        phase_d[v_q] = '0;
                    end else begin
                        phase_d[v_q] = phase_q[v_q] + inc_q[v_q];
                    end
                end else begin
                    phase_d[v_q] = '0;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // ROM data is valid exactly one cycle after the read strobe
                rom_data_d = iRom_data;
                state_d    = S_ACC;
            end
            S_ACC: begin
                acc_d = acc_sum_c;
                if (v_q == LAST_V) begin
                    sample_d     = sample_fmt_c;
                    sample_vld_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    v_d      = v_nxt_c;
                    state_d  = S_ISSUE;
                    rom_rd_d = key_q[v_nxt_c];
                    if (key_q[v_nxt_c]) begin
                        rom_addr_d = phase_q[v_nxt_c][PHASE_W-1 -: ADDR_W];
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            lrck_s1_q    <= 1'b0;
            lrck_s2_q    <= 1'b0;
            lrck_d_q     <= 1'b0;
            state_q      <= S_IDLE;
            v_q          <= '0;
            key_q        <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                inc_q[i]   <= '0;
                phase_q[i] <= '0;
            end
            acc_q        <= '0;
            rom_data_q   <= '0;
            rom_addr_q   <= '0;
            rom_rd_q     <= 1'b0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            lrck_s1_q    <= lrck_s1_d;
            lrck_s2_q    <= lrck_s2_d;
            lrck_d_q     <= lrck_d_d;
            state_q      <= state_d;
            v_q          <= v_d;
            key_q        <= key_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                inc_q[i]   <= inc_d[i];
                phase_q[i] <= phase_d[i];
            end
            acc_q        <= acc_d;
            rom_data_q   <= rom_data_d;
            rom_addr_q   <= rom_addr_d;
            rom_rd_q     <= rom_rd_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule
